sar_search: RTL

//  Successive-approximation search engine: the consumer side of the comparator interface.
//  It drives operand a of an external comparator and reads its is_a_greater/equal flags.

---
 rtl/sar_search.sv | 111 +++++++++++
 1 files changed

// File: rtl/sar_search.sv
// ---------------------------------------------------------------------------
// sar_search
//   Successive-approximation search engine. It drives operand a of an external
//   combinational comparator and uses the returned is-greater/is-equal flags
//   to recover, MSB first, the unknown value sitting on the comparator's b
//   input. A search takes at most SIZE compare cycles. It exits early as soon
//   as the comparator reports equality.
//
// Ports
//   clk            in   1               rising-edge clock
//   rst_n          in   1               asynchronous active-low reset
//   start          in   1               begin a search (sampled only when idle)
//   cmp_a          out  SIZE            trial value for comparator operand a
//   cmp_a_greater  in   1               comparator flag: cmp_a > b
//   cmp_equal      in   1               comparator flag: cmp_a == b
//   busy           out  1               high while searching or finishing
//   done           out  1               one-cycle pulse; result/steps valid
//   result         out  SIZE            recovered b, held until next completion
//   steps          out  $clog2(SIZE+1)  compare cycles used by the last search
// ---------------------------------------------------------------------------
module sar_search #(
    parameter int SIZE = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [SIZE-1:0]             cmp_a,
    input  logic                        cmp_a_greater,
    input  logic                        cmp_equal,
    output logic                        busy,
    output logic                        done,
    output logic [SIZE-1:0]             result,
    output logic [$clog2(SIZE+1)-1:0]   steps
);

    localparam int STEPS_W = $clog2(SIZE + 1);
    // A 1-bit operand still needs a 1-bit index register.
    localparam int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_reg;
    logic [SIZE-1:0]      trial_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [STEPS_W-1:0]   steps_reg;
    logic [SIZE-1:0]      result_reg;

    // The trial with the bit under test dropped when the comparator says it
    // overshot; otherwise the bit is confirmed and kept.
    logic [SIZE-1:0]      kept_next;

    always_comb begin
        kept_next = trial_reg;
        if (cmp_a_greater) begin
            kept_next = trial_reg & ~(SIZE'(1) << bit_idx_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            trial_reg   <= '0;
            bit_idx_reg <= '0;
            steps_reg   <= '0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        trial_reg   <= SIZE'(1) << (SIZE - 1);
                        bit_idx_reg <= IDX_W'(SIZE - 1);
                        steps_reg   <= '0;
                        state_reg   <= SEARCH;
                    end
                end
                SEARCH: begin
                    steps_reg <= steps_reg + STEPS_W'(1);
                    // Equality wins over greater: the current trial is exact.
                    if (cmp_equal) begin
                        result_reg <= trial_reg;
                        state_reg  <= DONE;
                    end else if (bit_idx_reg == '0) begin
                        result_reg <= kept_next;
                        state_reg  <= DONE;
                    end else begin
                        trial_reg   <= kept_next | (SIZE'(1) << (bit_idx_reg - IDX_W'(1)));
                        bit_idx_reg <= bit_idx_reg - IDX_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Operand a is only presented while a compare is in flight.
    assign cmp_a  = (state_reg == SEARCH) ? trial_reg : '0;
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign steps  = steps_reg;

endmodule
